ryu_anim_ctrl: RTL and testbench

Sequences Ryu's attack/block animations and selects which sprite layer (idle, punch, kick, block) the draw path shows.
- Runs in the VGA pixel-clock domain.
- Counts whole video frames, using the vsync falling edge as the frame tick.
- Changes the sprite selection only at a frame boundary, so a sprite never tears mid-frame.
- Drives the sprite-mux select and a hit-active flag for collision logic.

---
 rtl/ryu_anim_pkg.sv | 42 ++++
 rtl/ryu_anim_ctrl_frame_tick_gen.sv | 22 ++
 rtl/ryu_anim_ctrl.sv | 193 +++++++++++++++++++
 tb/tb_ryu_anim_ctrl.sv | 204 ++++++++++++++++++++
 4 files changed

// File: rtl/ryu_anim_pkg.sv
// Shared types and default frame durations for the Ryu animation controller.
// Optional build macro used by the controller: RYU_ANIM_REQ_BUFFER_EN.
package ryu_anim_pkg;

   typedef enum logic [1:0] {
      SPR_IDLE  = 2'd0,
      SPR_PUNCH = 2'd1,
      SPR_KICK  = 2'd2,
      SPR_BLOCK = 2'd3
   } sprite_sel_t;

   typedef enum logic [2:0] {
      ST_IDLE     = 3'd0,
      ST_STARTUP  = 3'd1,
      ST_ACTIVE   = 3'd2,
      ST_RECOVERY = 3'd3,
      ST_BLOCK    = 3'd4
   } anim_state_t;

   typedef enum logic {
      ATK_PUNCH = 1'b0,
      ATK_KICK  = 1'b1
   } atk_t;

   localparam int DEF_PUNCH_STARTUP  = 3;
   localparam int DEF_PUNCH_ACTIVE   = 4;
   localparam int DEF_PUNCH_RECOVERY = 6;
   localparam int DEF_KICK_STARTUP   = 5;
   localparam int DEF_KICK_ACTIVE    = 4;
   localparam int DEF_KICK_RECOVERY  = 10;
   localparam int DEF_CNT_W          = 6;

   // Recovery shows the idle sprite so the pose visibly relaxes before the FSM is free.
   function automatic sprite_sel_t spr_of(anim_state_t st, atk_t atk);
      case (st)
         ST_STARTUP, ST_ACTIVE: spr_of = (atk == ATK_PUNCH) ? SPR_PUNCH : SPR_KICK;
         ST_BLOCK:              spr_of = SPR_BLOCK;
         default:               spr_of = SPR_IDLE;
      endcase
   endfunction

endpackage

// File: rtl/ryu_anim_ctrl_frame_tick_gen.sv
// Vsync falling-edge detector: one clk pulse on the first low sample of vs.
// Shared with the Ken controller.
module frame_tick_gen (
   input  logic clk_i,
   input  logic rst_i,
   input  logic vs_i,
   output logic tick_o
);

   logic vs_q;

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         vs_q <= 1'b0;
      end else begin
         vs_q <= vs_i;
      end
   end

   assign tick_o = vs_q & ~vs_i;

endmodule

// File: rtl/ryu_anim_ctrl.sv
// Ryu attack/block animation sequencer; sprite changes only on vsync frame ticks.
// Define RYU_ANIM_REQ_BUFFER_EN to buffer one attack request made during RECOVERY.
module ryu_anim_ctrl
   import ryu_anim_pkg::*;
#(
   parameter int PUNCH_STARTUP  = DEF_PUNCH_STARTUP,
   parameter int PUNCH_ACTIVE   = DEF_PUNCH_ACTIVE,
   parameter int PUNCH_RECOVERY = DEF_PUNCH_RECOVERY,
   parameter int KICK_STARTUP   = DEF_KICK_STARTUP,
   parameter int KICK_ACTIVE    = DEF_KICK_ACTIVE,
   parameter int KICK_RECOVERY  = DEF_KICK_RECOVERY,
   parameter int CNT_W          = DEF_CNT_W
) (
   input  logic             vga_clk,
   input  logic             Reset,
   input  logic             vs,
   input  logic             punch_req,
   input  logic             kick_req,
   input  logic             block_hold,
   output logic [1:0]       sprite_sel,
   output logic             hit_active,
   output logic             busy,
   output logic [CNT_W-1:0] frame_cnt
);

   localparam int MAX_DUR = (1 << CNT_W) - 1;

   if (PUNCH_STARTUP < 1 || PUNCH_ACTIVE < 1 || PUNCH_RECOVERY < 1 ||
       KICK_STARTUP < 1 || KICK_ACTIVE < 1 || KICK_RECOVERY < 1 ||
       PUNCH_STARTUP > MAX_DUR || PUNCH_ACTIVE > MAX_DUR || PUNCH_RECOVERY > MAX_DUR ||
       KICK_STARTUP > MAX_DUR || KICK_ACTIVE > MAX_DUR || KICK_RECOVERY > MAX_DUR) begin : g_bad_dur
      $error("ryu_anim_ctrl: phase durations must be 1..2^CNT_W-1");
   end

   localparam logic [CNT_W-1:0] P_S_LAST = CNT_W'(PUNCH_STARTUP - 1);
   localparam logic [CNT_W-1:0] P_A_LAST = CNT_W'(PUNCH_ACTIVE - 1);
   localparam logic [CNT_W-1:0] P_R_LAST = CNT_W'(PUNCH_RECOVERY - 1);
   localparam logic [CNT_W-1:0] K_S_LAST = CNT_W'(KICK_STARTUP - 1);
   localparam logic [CNT_W-1:0] K_A_LAST = CNT_W'(KICK_ACTIVE - 1);
   localparam logic [CNT_W-1:0] K_R_LAST = CNT_W'(KICK_RECOVERY - 1);

   logic             tick;
   logic             preq_q, kreq_q;
   logic             p_edge, k_edge;
   anim_state_t      state_q, state_d;
   atk_t             atk_q, atk_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [CNT_W-1:0] last_cnt;
   logic             pend_p_q, pend_p_d, pend_k_q, pend_k_d;
   sprite_sel_t      spr_q;
   logic             hit_q, busy_q;
`ifdef RYU_ANIM_REQ_BUFFER_EN
   logic             buf_v_q, buf_v_d;
   atk_t             buf_atk_q, buf_atk_d;
`endif

   frame_tick_gen u_tick (
      .clk_i  (vga_clk),
      .rst_i  (Reset),
      .vs_i   (vs),
      .tick_o (tick)
   );

   assign p_edge = punch_req & ~preq_q;
   assign k_edge = kick_req & ~kreq_q;

   always_comb begin
      last_cnt = '0;
      case (state_q)
         ST_STARTUP:  last_cnt = (atk_q == ATK_PUNCH) ? P_S_LAST : K_S_LAST;
         ST_ACTIVE:   last_cnt = (atk_q == ATK_PUNCH) ? P_A_LAST : K_A_LAST;
         ST_RECOVERY: last_cnt = (atk_q == ATK_PUNCH) ? P_R_LAST : K_R_LAST;
         default:     last_cnt = '0;
      endcase
   end

   always_comb begin
      state_d  = state_q;
      atk_d    = atk_q;
      cnt_d    = cnt_q;
      pend_p_d = pend_p_q;
      pend_k_d = pend_k_q;
`ifdef RYU_ANIM_REQ_BUFFER_EN
      buf_v_d   = buf_v_q;
      buf_atk_d = buf_atk_q;
`endif
      case (state_q)
         ST_IDLE: begin
            if (tick) begin
               // Both latches clear: either consumed, or a losing kick is dropped.
               if (pend_p_q) begin
                  atk_d   = ATK_PUNCH;
                  state_d = ST_STARTUP;
               end else if (pend_k_q) begin
                  atk_d   = ATK_KICK;
                  state_d = ST_STARTUP;
               end else if (block_hold) begin
                  state_d = ST_BLOCK;
               end
               pend_p_d = 1'b0;
               pend_k_d = 1'b0;
               cnt_d    = '0;
            end
         end
         ST_STARTUP, ST_ACTIVE, ST_RECOVERY: begin
            if (tick) begin
               if (cnt_q == last_cnt) begin
                  cnt_d = '0;
                  if (state_q == ST_STARTUP) begin
                     state_d = ST_ACTIVE;
                  end else if (state_q == ST_ACTIVE) begin
                     state_d = ST_RECOVERY;
                  end else begin
                     state_d = ST_IDLE;
`ifdef RYU_ANIM_REQ_BUFFER_EN
                     if (buf_v_q) begin
                        state_d = ST_STARTUP;
                        atk_d   = buf_atk_q;
                        buf_v_d = 1'b0;
                     end
`endif
                  end
               end else begin
                  cnt_d = cnt_q + 1'b1;
               end
            end
         end
         ST_BLOCK: begin
            if (tick && !block_hold) begin
               state_d = ST_IDLE;
            end
         end
         default: state_d = ST_IDLE;
      endcase

      // New edges are only remembered while the FSM stays idle.
      if (state_q == ST_IDLE && state_d == ST_IDLE) begin
         if (p_edge) pend_p_d = 1'b1;
         if (k_edge) pend_k_d = 1'b1;
      end
`ifdef RYU_ANIM_REQ_BUFFER_EN
      if (state_q == ST_RECOVERY && state_d == ST_RECOVERY) begin
         if (p_edge) begin
            buf_v_d   = 1'b1;
            buf_atk_d = ATK_PUNCH;
         end else if (k_edge) begin
            buf_v_d   = 1'b1;
            buf_atk_d = ATK_KICK;
         end
      end
`endif
   end

   always_ff @(posedge vga_clk or posedge Reset) begin
      if (Reset) begin
         preq_q   <= 1'b0;
         kreq_q   <= 1'b0;
         state_q  <= ST_IDLE;
         atk_q    <= ATK_PUNCH;
         cnt_q    <= '0;
         pend_p_q <= 1'b0;
         pend_k_q <= 1'b0;
         spr_q    <= SPR_IDLE;
         hit_q    <= 1'b0;
         busy_q   <= 1'b0;
`ifdef RYU_ANIM_REQ_BUFFER_EN
         buf_v_q   <= 1'b0;
         buf_atk_q <= ATK_PUNCH;
`endif
      end else begin
         preq_q   <= punch_req;
         kreq_q   <= kick_req;
         state_q  <= state_d;
         atk_q    <= atk_d;
         cnt_q    <= cnt_d;
         pend_p_q <= pend_p_d;
         pend_k_q <= pend_k_d;
         spr_q    <= spr_of(state_d, atk_d);
         hit_q    <= (state_d == ST_ACTIVE);
         busy_q   <= (state_d != ST_IDLE);
`ifdef RYU_ANIM_REQ_BUFFER_EN
         buf_v_q   <= buf_v_d;
         buf_atk_q <= buf_atk_d;
`endif
      end
   end

   assign sprite_sel = spr_q;
   assign hit_active = hit_q;
   assign busy       = busy_q;
   assign frame_cnt  = cnt_q;

endmodule

// File: tb/tb_ryu_anim_ctrl.sv
// Directed bench for ryu_anim_ctrl with default durations; expectations adapt to RYU_ANIM_REQ_BUFFER_EN.
module tb_ryu_anim_ctrl;

   logic       vga_clk = 1'b0;
   logic       Reset;
   logic       vs;
   logic       punch_req;
   logic       kick_req;
   logic       block_hold;
   logic [1:0] sprite_sel;
   logic       hit_active;
   logic       busy;
   logic [5:0] frame_cnt;

   int n_checks = 0;
   int n_errors = 0;

   ryu_anim_ctrl dut (
      .vga_clk    (vga_clk),
      .Reset      (Reset),
      .vs         (vs),
      .punch_req  (punch_req),
      .kick_req   (kick_req),
      .block_hold (block_hold),
      .sprite_sel (sprite_sel),
      .hit_active (hit_active),
      .busy       (busy),
      .frame_cnt  (frame_cnt)
   );

   always #5 vga_clk = ~vga_clk;

   task automatic check_val(input string tag, input int act, input int exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0d, expected %0d", tag, act, exp);
      end else begin
         $display("ok   %s: %0d", tag, act);
      end
   endtask

   // One video frame: vs low for low_cyc cycles (one tick), then high.
   task automatic do_frame(input int low_cyc);
      @(negedge vga_clk);
      vs = 1'b0;
      repeat (low_cyc) @(negedge vga_clk);
      vs = 1'b1;
      repeat (4) @(negedge vga_clk);
   endtask

   task automatic press(input logic p, input logic k);
      @(negedge vga_clk);
      punch_req = p;
      kick_req  = k;
      @(negedge vga_clk);
      punch_req = 1'b0;
      kick_req  = 1'b0;
   endtask

   // Expected punch outputs after tick n (punch edge latched before tick 1).
   function automatic int exp_spr(input int n);
      return (n >= 1 && n < 8) ? 1 : 0;
   endfunction
   function automatic int exp_hit(input int n);
      return (n >= 4 && n < 8) ? 1 : 0;
   endfunction
   function automatic int exp_busy(input int n);
      return (n >= 1 && n < 14) ? 1 : 0;
   endfunction
   function automatic int exp_cnt(input int n);
      if (n >= 1 && n <= 3) return n - 1;
      if (n >= 4 && n <= 7) return n - 4;
      if (n >= 8 && n <= 13) return n - 8;
      return 0;
   endfunction

   initial begin
      bit saw_kick;
      Reset      = 1'b1;
      vs         = 1'b1;
      punch_req  = 1'b0;
      kick_req   = 1'b0;
      block_hold = 1'b0;
      repeat (3) @(negedge vga_clk);
      Reset = 1'b0;
      repeat (2) @(negedge vga_clk);

      check_val("rst_sprite", sprite_sel, 0);
      check_val("rst_hit", hit_active, 0);
      check_val("rst_busy", busy, 0);
      check_val("rst_cnt", frame_cnt, 0);

      // Full punch sequence.
      press(1'b1, 1'b0);
      for (int n = 1; n <= 14; n++) begin
         do_frame(3);
         check_val($sformatf("punch_t%0d_spr", n), sprite_sel, exp_spr(n));
         check_val($sformatf("punch_t%0d_hit", n), hit_active, exp_hit(n));
         check_val($sformatf("punch_t%0d_busy", n), busy, exp_busy(n));
         check_val($sformatf("punch_t%0d_cnt", n), frame_cnt, exp_cnt(n));
      end

      // Simultaneous punch and kick: punch only, kick dropped.
      press(1'b1, 1'b1);
      saw_kick = 1'b0;
      for (int n = 1; n <= 16; n++) begin
         do_frame(3);
         if (sprite_sel == 2'd2) saw_kick = 1'b1;
         if (n == 1 || n == 13 || n == 14 || n == 16) begin
            check_val($sformatf("both_t%0d_busy", n), busy, exp_busy(n));
            check_val($sformatf("both_t%0d_spr", n), sprite_sel, exp_spr(n));
         end
      end
      check_val("both_no_kick", saw_kick, 0);

      // Block held five frames, kick pressed during block is discarded.
      @(negedge vga_clk);
      block_hold = 1'b1;
      for (int n = 1; n <= 5; n++) begin
         do_frame(3);
         check_val($sformatf("block_t%0d_spr", n), sprite_sel, 3);
         check_val($sformatf("block_t%0d_busy", n), busy, 1);
         if (n == 2) press(1'b0, 1'b1);
      end
      block_hold = 1'b0;
      do_frame(3);
      check_val("block_rel_spr", sprite_sel, 0);
      check_val("block_rel_busy", busy, 0);
      do_frame(3);
      check_val("block_after_spr", sprite_sel, 0);
      check_val("block_after_busy", busy, 0);

      // Kick during punch ACTIVE: ignored in both builds.
      press(1'b1, 1'b0);
      for (int n = 1; n <= 15; n++) begin
         do_frame(3);
         if (n == 5) begin
            check_val("act_kick_hit", hit_active, 1);
            press(1'b0, 1'b1);
         end
      end
      check_val("act_kick_spr", sprite_sel, 0);
      check_val("act_kick_busy", busy, 0);

      // Kick during punch RECOVERY.
      press(1'b1, 1'b0);
      for (int n = 1; n <= 14; n++) begin
         do_frame(3);
         if (n == 9) begin
            check_val("rec_kick_spr_rec", sprite_sel, 0);
            check_val("rec_kick_busy_rec", busy, 1);
            press(1'b0, 1'b1);
         end
      end
`ifdef RYU_ANIM_REQ_BUFFER_EN
      check_val("rec_kick_busy", busy, 1);
      check_val("rec_kick_spr", sprite_sel, 2);
      check_val("rec_kick_cnt", frame_cnt, 0);
      for (int n = 1; n <= 19; n++) begin
         do_frame(3);
         if (n == 5) check_val("rec_kick_hit", hit_active, 1);
         if (n == 18) check_val("rec_kick_busy_end", busy, 1);
         if (n == 19) check_val("rec_kick_idle", busy, 0);
      end
`else
      check_val("rec_kick_busy", busy, 0);
      check_val("rec_kick_spr", sprite_sel, 0);
      do_frame(3);
      check_val("rec_kick_stay_idle", busy, 0);
`endif

      // Long vsync low: exactly one tick per frame.
      press(1'b1, 1'b0);
      do_frame(3);
      check_val("vs_long_cnt0", frame_cnt, 0);
      do_frame(50);
      check_val("vs_long_cnt1", frame_cnt, 1);
      do_frame(50);
      check_val("vs_long_cnt2", frame_cnt, 2);
      for (int n = 4; n <= 14; n++) do_frame(3);
      check_val("vs_long_idle", busy, 0);

      // Asynchronous reset in the middle of ACTIVE.
      press(1'b1, 1'b0);
      for (int n = 1; n <= 5; n++) do_frame(3);
      check_val("arst_pre_hit", hit_active, 1);
      @(negedge vga_clk);
      #1 Reset = 1'b1;
      #1;
      check_val("arst_spr", sprite_sel, 0);
      check_val("arst_hit", hit_active, 0);
      check_val("arst_busy", busy, 0);
      check_val("arst_cnt", frame_cnt, 0);
      @(negedge vga_clk);
      Reset = 1'b0;
      do_frame(3);
      check_val("arst_after_busy", busy, 0);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
